// File: rtl/aura_pkg.sv
// Shared constants, register map helpers and FSM encoding for the AURA stereo mixer.
package aura_pkg;

    localparam logic [7:0] VOL_UNITY = 8'h80;
    localparam int         VOL_BASE  = 0;

    localparam int CLIP_L  = 0;
    localparam int CLIP_R  = 1;
    localparam int OVERRUN = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_e;

    // Status sits directly after the two volume registers of every channel.
    function automatic int status_addr(input int nch);
        return VOL_BASE + 2 * nch;
    endfunction

    function automatic int acc_w(input int nch, input int sw, input int vw);
        return sw + vw + $clog2(nch) + 1;
    endfunction

endpackage

// File: rtl/aura_mac_lane.sv
// One side of the mixer: scales each sample by its volume, accumulates, and saturates.
module aura_mac_lane
    import aura_pkg::*;
#(
    parameter int NCH = 4,
    parameter int SW  = 16,
    parameter int VW  = 8
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clr_i,
    input  logic          mac_i,
    input  logic          out_i,
    input  logic [SW-1:0] smp_i,
    input  logic [VW-1:0] vol_i,
    output logic [SW-1:0] chan_o,
    output logic          clip_o
);

    localparam int ACC_W = acc_w(NCH, SW, VW);
    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-SW+1){1'b0}}, {(SW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-SW+1){1'b1}}, {(SW-1){1'b0}}};

    logic signed [SW+VW:0]  prod;
    logic signed [SW+VW:0]  scaled;
    logic signed [ACC_W-1:0] acc_add;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic        [SW-1:0]    chan_q;
    logic        [SW:0]      sat_res;

    // Returns {clipped, saturated sample}.
    function automatic logic [SW:0] sat(input logic signed [ACC_W-1:0] a);
        if (a > MAXV) return {1'b1, 1'b0, {(SW-1){1'b1}}};
        if (a < MINV) return {1'b1, 1'b1, {(SW-1){1'b0}}};
        return {1'b0, a[SW-1:0]};
    endfunction

    assign prod    = $signed({{(VW+1){smp_i[SW-1]}}, smp_i}) * $signed({{SW{1'b0}}, vol_i});
    assign scaled  = prod >>> (VW-1);
    assign acc_add = {{(ACC_W-SW-VW-1){scaled[SW+VW]}}, scaled};
    assign sat_res = sat(acc_q);

    always_comb begin
        acc_d = acc_q;
        if (clr_i)      acc_d = '0;
        else if (mac_i) acc_d = acc_q + acc_add;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_q  <= '0;
            chan_q <= '0;
        end else begin
            acc_q <= acc_d;
            if (out_i) chan_q <= sat_res[SW-1:0];
        end
    end

    assign chan_o = chan_q;
    assign clip_o = out_i & sat_res[SW];

endmodule

// File: rtl/aura_mixer.sv
// N-channel stereo mixer: volume register file, frame FSM with input snapshot,
// and one time-multiplexed MAC lane per side.
module aura_mixer
    import aura_pkg::*;
#(
    parameter int          NCH       = 4,
    parameter int          SW        = 16,
    parameter int          VW        = 8,
    parameter logic [VW-1:0] VOL_RESET = 8'h40,
    localparam int         AW        = $clog2(2*NCH+1)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NCH*SW-1:0] smp_l_i,
    input  logic [NCH*SW-1:0] smp_r_i,
    input  logic              start_i,
    input  logic              reg_we_i,
    input  logic [AW-1:0]     reg_addr_i,
    input  logic [VW-1:0]     reg_wdata_i,
    output logic [VW-1:0]     reg_rdata_o,
    output logic [SW-1:0]     l_chan_o,
    output logic [SW-1:0]     r_chan_o,
    output logic              strobe_o,
    output logic              busy_o
);

    localparam int            CW          = $clog2(NCH);
    localparam logic [AW-1:0] STATUS_ADDR = AW'(status_addr(NCH));

    state_e              state_q;
    logic [CW-1:0]       ch_q;
    logic                strobe_q;
    logic [NCH*SW-1:0]   snap_l_q, snap_r_q;
    logic [VW-1:0]       vol_l_q [NCH];
    logic [VW-1:0]       vol_r_q [NCH];
    logic [VW-1:0]       svol_l_q [NCH];
    logic [VW-1:0]       svol_r_q [NCH];
    logic [2:0]          status_q, status_d;
    logic                clr_acc, do_mac, do_out, clip_l, clip_r, overrun;

    assign clr_acc = (state_q == IDLE) && start_i;
    assign do_mac  = (state_q == MAC);
    assign do_out  = (state_q == OUT);
    assign overrun = (state_q != IDLE) && start_i;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            strobe_q <= 1'b0;
            snap_l_q <= '0;
            snap_r_q <= '0;
            for (int k = 0; k < NCH; k++) begin
                svol_l_q[k] <= '0;
                svol_r_q[k] <= '0;
            end
        end else begin
            strobe_q <= 1'b0;
            case (state_q)
                IDLE: if (start_i) begin
                    snap_l_q <= smp_l_i;
                    snap_r_q <= smp_r_i;
                    for (int k = 0; k < NCH; k++) begin
                        svol_l_q[k] <= vol_l_q[k];
                        svol_r_q[k] <= vol_r_q[k];
                    end
                    ch_q    <= '0;
                    state_q <= MAC;
                end
                MAC: begin
                    ch_q <= ch_q + CW'(1);
                    if (ch_q == CW'(NCH-1)) state_q <= OUT;
                end
                OUT: begin
                    strobe_q <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < NCH; k++) begin
                vol_l_q[k] <= VOL_RESET;
                vol_r_q[k] <= VOL_RESET;
            end
        end else if (reg_we_i) begin
            for (int k = 0; k < NCH; k++) begin
                if (reg_addr_i == AW'(2*k))   vol_l_q[k] <= reg_wdata_i;
                if (reg_addr_i == AW'(2*k+1)) vol_r_q[k] <= reg_wdata_i;
            end
        end
    end

    // Clearing write and a new flag in the same cycle: the flag survives.
    always_comb begin
        status_d = status_q;
        if (reg_we_i && reg_addr_i == STATUS_ADDR) status_d = '0;
        if (clip_l)  status_d[CLIP_L]  = 1'b1;
        if (clip_r)  status_d[CLIP_R]  = 1'b1;
        if (overrun) status_d[OVERRUN] = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) status_q <= '0;
        else         status_q <= status_d;
    end

    always_comb begin
        reg_rdata_o = '0;
        for (int k = 0; k < NCH; k++) begin
            if (reg_addr_i == AW'(2*k))   reg_rdata_o = vol_l_q[k];
            if (reg_addr_i == AW'(2*k+1)) reg_rdata_o = vol_r_q[k];
        end
        if (reg_addr_i == STATUS_ADDR) reg_rdata_o = {{(VW-3){1'b0}}, status_q};
    end

    aura_mac_lane #(.NCH(NCH), .SW(SW), .VW(VW)) u_lane_l (
        .clk    (clk),
        .resetn (resetn),
        .clr_i  (clr_acc),
        .mac_i  (do_mac),
        .out_i  (do_out),
        .smp_i  (snap_l_q[ch_q*SW +: SW]),
        .vol_i  (svol_l_q[ch_q]),
        .chan_o (l_chan_o),
        .clip_o (clip_l)
    );

    aura_mac_lane #(.NCH(NCH), .SW(SW), .VW(VW)) u_lane_r (
        .clk    (clk),
        .resetn (resetn),
        .clr_i  (clr_acc),
        .mac_i  (do_mac),
        .out_i  (do_out),
        .smp_i  (snap_r_q[ch_q*SW +: SW]),
        .vol_i  (svol_r_q[ch_q]),
        .chan_o (r_chan_o),
        .clip_o (clip_r)
    );

    assign strobe_o = strobe_q;
    assign busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_aura_mixer.sv
// Self-checking bench for aura_mixer (NCH=4, SW=16, VW=8) with a floor-division reference model.
module tb_aura_mixer;
    import aura_pkg::*;

    localparam int NCH = 4;
    localparam int SW  = 16;
    localparam int VW  = 8;
    localparam int AW  = $clog2(2*NCH+1);

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [NCH*SW-1:0] smp_l_i = '0, smp_r_i = '0;
    logic              start_i = 1'b0, reg_we_i = 1'b0;
    logic [AW-1:0]     reg_addr_i = '0;
    logic [VW-1:0]     reg_wdata_i = '0;
    logic [VW-1:0]     reg_rdata_o;
    logic [SW-1:0]     l_chan_o, r_chan_o;
    logic              strobe_o, busy_o;

    int checks = 0, failures = 0;
    int sl[NCH], sr[NCH], vl[NCH], vr[NCH];
    bit [2:0] st_m = '0;

    aura_mixer #(.NCH(NCH), .SW(SW), .VW(VW), .VOL_RESET(8'h40)) dut (
        .clk(clk), .resetn(resetn), .smp_l_i(smp_l_i), .smp_r_i(smp_r_i),
        .start_i(start_i), .reg_we_i(reg_we_i), .reg_addr_i(reg_addr_i),
        .reg_wdata_i(reg_wdata_i), .reg_rdata_o(reg_rdata_o), .l_chan_o(l_chan_o),
        .r_chan_o(r_chan_o), .strobe_o(strobe_o), .busy_o(busy_o)
    );

    always #20 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Each channel contributes floor(sample*vol/2^(VW-1)); the sum is clamped to 16 bits.
    function automatic int model(input bit right, output bit clip);
        longint acc = 0;
        longint p, q;
        for (int k = 0; k < NCH; k++) begin
            p = right ? longint'(sr[k]) * longint'(vr[k]) : longint'(sl[k]) * longint'(vl[k]);
            q = p / 128;
            if (p < 0 && (p % 128) != 0) q = q - 1;
            acc += q;
        end
        clip = 1'b0;
        if (acc > 32767)  begin clip = 1'b1; return 32'h7FFF; end
        if (acc < -32768) begin clip = 1'b1; return 32'h8000; end
        return int'(acc) & 32'hFFFF;
    endfunction

    task automatic wr(input int addr, input int data);
        @(negedge clk);
        reg_we_i = 1'b1; reg_addr_i = AW'(addr); reg_wdata_i = VW'(data);
        @(negedge clk);
        reg_we_i = 1'b0;
    endtask

    task automatic set_vol(input int k, input int l, input int r);
        wr(2*k, l);   vl[k] = l;
        wr(2*k+1, r); vr[k] = r;
    endtask

    task automatic rd_chk(input string tag, input int addr, input int exp);
        reg_addr_i = AW'(addr);
        #1;
        chk(tag, 32'(reg_rdata_o), exp);
    endtask

    task automatic clr_status();
        wr(status_addr(NCH), 8'hA5);
        st_m = '0;
    endtask

    task automatic drive_samples();
        for (int k = 0; k < NCH; k++) begin
            smp_l_i[k*SW +: SW] = sl[k][15:0];
            smp_r_i[k*SW +: SW] = sr[k][15:0];
        end
    endtask

    task automatic run_frame(input string tag);
        int el, er, cyc;
        bit cl, cr;
        el = model(1'b0, cl);
        er = model(1'b1, cr);
        @(negedge clk);
        drive_samples();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk({tag, "_busy"}, 32'(busy_o), 1);
        cyc = 0;
        while (!strobe_o && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_lat"}, cyc, NCH + 1);
        chk({tag, "_l"}, 32'(l_chan_o), el);
        chk({tag, "_r"}, 32'(r_chan_o), er);
        st_m[CLIP_L] |= cl;
        st_m[CLIP_R] |= cr;
    endtask

    initial begin
        int nstb, lat, lval;
        for (int k = 0; k < NCH; k++) begin sl[k] = 0; sr[k] = 0; vl[k] = 8'h40; vr[k] = 8'h40; end
        repeat (3) @(negedge clk);
        chk("rst_l", 32'(l_chan_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_strobe", 32'(strobe_o), 0);
        rd_chk("rst_vol0", 0, 8'h40);
        rd_chk("rst_vol7", 7, 8'h40);
        rd_chk("rst_status", status_addr(NCH), 0);
        rd_chk("unmapped", 15, 0);

        sl[0] = 16'h2000;
        run_frame("default");

        for (int k = 0; k < NCH; k++) begin set_vol(k, VOL_UNITY, VOL_UNITY); sl[k] = 16'h1000; end
        run_frame("unity");
        rd_chk("unity_vol0", 0, 8'h80);
        rd_chk("unity_status", status_addr(NCH), 0);

        for (int k = 0; k < NCH; k++) begin sl[k] = 0; sr[k] = 0; end
        sl[0] = 16'h7FFF; sl[1] = 16'h7FFF;
        set_vol(0, 8'hFF, 8'h80); set_vol(1, 8'hFF, 8'h80);
        run_frame("posclip");
        rd_chk("posclip_status", status_addr(NCH), 1);
        clr_status();
        rd_chk("status_clear", status_addr(NCH), 0);

        sl[0] = 0; sl[1] = 0;
        sr[0] = -32768; sr[1] = -32768;
        set_vol(0, 8'h80, 8'hFF); set_vol(1, 8'h80, 8'hFF);
        run_frame("negclip");
        rd_chk("negclip_status", status_addr(NCH), 2);
        clr_status();
        sr[0] = -1; sr[1] = 0;
        set_vol(0, 8'h80, 8'h40);
        run_frame("floor");

        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < NCH; k++) begin
                set_vol(k, $urandom_range(0, 255), $urandom_range(0, 255));
                sl[k] = shortint'($urandom_range(0, 65535));
                sr[k] = shortint'($urandom_range(0, 65535));
            end
            run_frame($sformatf("rand%0d", it));
            rd_chk($sformatf("rand%0d_status", it), status_addr(NCH), int'(st_m));
            clr_status();
        end

        // Overlapping start and mid-frame volume write.
        for (int k = 0; k < NCH; k++) begin set_vol(k, 8'h80, 8'h80); sl[k] = 16'h1000; sr[k] = 0; end
        @(negedge clk);
        drive_samples();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        reg_we_i = 1'b1; reg_addr_i = AW'(6); reg_wdata_i = 8'h00;
        @(negedge clk);
        reg_we_i = 1'b0;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        nstb = 0; lat = 0; lval = 0;
        for (int i = 3; i < 20; i++) begin
            @(negedge clk);
            if (strobe_o) begin nstb++; lat = i; lval = int'(l_chan_o); end
        end
        chk("ovr_strobes", nstb, 1);
        chk("ovr_lat", lat, NCH + 1);
        chk("ovr_l_oldvol", lval, 32'h4000);
        rd_chk("ovr_status", status_addr(NCH), 4);
        rd_chk("ovr_newvol", 6, 0);
        vl[3] = 0;
        clr_status();
        run_frame("newvol");

        // Asynchronous reset two cycles into a frame.
        @(negedge clk);
        drive_samples();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("arst_l", 32'(l_chan_o), 0);
        chk("arst_r", 32'(r_chan_o), 0);
        chk("arst_busy", 32'(busy_o), 0);
        chk("arst_strobe", 32'(strobe_o), 0);
        @(negedge clk);
        resetn = 1'b1;
        nstb = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (strobe_o) nstb++;
        end
        chk("arst_nostrobe", nstb, 0);
        rd_chk("arst_vol6", 6, 8'h40);
        rd_chk("arst_vol1", 1, 8'h40);
        rd_chk("arst_status", status_addr(NCH), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
